// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered frame memory.
// Each row gets a blanking gap and then a dwell period. Host writes go to the
// back buffer. A requested front/back swap is applied only at a frame boundary
// or while the scanner is idle.
module led_matrix_scanner #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned DWELL      = 1000,
  parameter int unsigned BLANK      = 16,
  parameter bit          ROW_ACTIVE = 1'b1,
  parameter bit          COL_ACTIVE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic [ROWS-1:0]         row_out,
  output logic [COLS-1:0]         col_out
);

  localparam int unsigned RW      = $clog2(ROWS);
  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [ROWS-1:0] ROW_OFF    = {ROWS{~ROW_ACTIVE}};
  localparam logic [COLS-1:0] COL_OFF    = {COLS{~COL_ACTIVE}};
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  state_e          state_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   cnt_q;
  logic            front_q;    // 0 = buffer A is displayed
  logic            pending_q;
  logic [COLS-1:0] mem_q [2][ROWS];

  logic            frame_end;
  logic            swap_now;
  logic            back_sel;
  logic [COLS-1:0] front_row;
  logic [ROWS-1:0] row_onehot;

  // Frame-boundary detection, swap decision and the row pattern for the next ON entry.
  always_comb begin
    frame_end  = (state_q == StOn) && (cnt_q == DWELL_LAST) && (row_q == ROW_LAST);
    swap_now   = pending_q && ((state_q == StIdle) || (frame_end && enable));
    back_sel   = ~front_q;
    front_row  = mem_q[front_q][row_q];
    row_onehot = ROWS'(1) << row_q;
  end

  // Frame memory. Host writes always land in the buffer that is currently the back buffer,
  // so a write on the swap edge is carried into the new front buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_row == RW'(r)) begin
          mem_q[back_sel][r] <= wr_data;
        end
      end
    end
  end

  // Scan FSM with registered outputs, buffer selection and swap handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      cnt_q       <= '0;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      row_out     <= ROW_OFF;
      col_out     <= COL_OFF;
    end else begin
      frame_start <= 1'b0;
      swap_ack    <= swap_now;
      if (swap_now) begin
        front_q <= ~front_q;
      end
      // A request on the swap edge re-arms pending for the next boundary.
      pending_q <= swap_req | (pending_q & ~swap_now);

      if (!enable) begin
        state_q <= StIdle;
        row_q   <= '0;
        cnt_q   <= '0;
        row_out <= ROW_OFF;
        col_out <= COL_OFF;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q     <= StBlank;
            row_q       <= '0;
            cnt_q       <= '0;
            frame_start <= 1'b1;
            row_out     <= ROW_OFF;
            col_out     <= COL_OFF;
          end
          StBlank: begin
            if (cnt_q == BLANK_LAST) begin
              state_q <= StOn;
              cnt_q   <= '0;
              row_out <= row_onehot ^ ROW_OFF;
              col_out <= front_row ^ COL_OFF;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StOn: begin
            if (cnt_q == DWELL_LAST) begin
              state_q <= StBlank;
              cnt_q   <= '0;
              row_out <= ROW_OFF;
              col_out <= COL_OFF;
              if (row_q == ROW_LAST) begin
                row_q       <= '0;
                frame_start <= 1'b1;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner. The scan is modelled as a position within the frame.
// The two buffers are modelled as plain arrays. The bench uses directed scenarios with
// literal expectations, then a randomised soak checked against the model on every cycle.
module tb_led_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int PER   = BLANK + DWELL;
  localparam int FRAME = ROWS * PER;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            enable   = 1'b0;
  logic            wr_en    = 1'b0;
  logic [1:0]      wr_row   = '0;
  logic [COLS-1:0] wr_data  = '0;
  logic            swap_req = 1'b0;
  logic            swap_ack;
  logic            frame_start;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK),
    .ROW_ACTIVE(1'b1), .COL_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .row_out(row_out), .col_out(col_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: scanning flag, position in frame, front/back images, pending flag.
  bit              m_running;
  int              m_pos;
  bit              m_pending;
  logic [COLS-1:0] m_front [ROWS];
  logic [COLS-1:0] m_back  [ROWS];
  logic [ROWS-1:0] e_row;
  logic [COLS-1:0] e_col;
  logic            e_fs;
  logic            e_ack;
  bit              m_bound;
  bit              m_swap;
  logic [COLS-1:0] m_tmp;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_running = 1'b0;
      m_pos     = 0;
      m_pending = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        m_front[i] = '0;
        m_back[i]  = '0;
      end
      e_row = '0;
      e_col = '1;
      e_fs  = 1'b0;
      e_ack = 1'b0;
    end else begin
      m_bound = m_running && (m_pos == FRAME - 1);
      m_swap  = m_pending && (!m_running || (m_bound && enable));
      if (wr_en && int'(wr_row) < ROWS) m_back[wr_row] = wr_data;
      if (m_swap) begin
        for (int i = 0; i < ROWS; i++) begin
          m_tmp      = m_front[i];
          m_front[i] = m_back[i];
          m_back[i]  = m_tmp;
        end
      end
      m_pending = swap_req || (m_pending && !m_swap);
      e_ack     = m_swap;
      if (!enable) begin
        m_running = 1'b0;
        m_pos     = 0;
        e_fs      = 1'b0;
      end else if (!m_running) begin
        m_running = 1'b1;
        m_pos     = 0;
        e_fs      = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        e_fs  = (m_pos == 0);
      end
      if (m_running && (m_pos % PER) >= BLANK) begin
        e_row = ROWS'(1) << (m_pos / PER);
        e_col = ~m_front[m_pos / PER];
      end else begin
        e_row = '0;
        e_col = '1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_row_out", 32'(row_out), 32'(e_row));
      chk("model_col_out", 32'(col_out), 32'(e_col));
      chk("model_frame_start", 32'(frame_start), 32'(e_fs));
      chk("model_swap_ack", 32'(swap_ack), 32'(e_ack));
    end
  end

  task automatic wait_pos(input int p);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_running && m_pos == p) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_pos: frame position %0d not reached within 200 cycles", p);
  endtask

  int acks;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_row_out", 32'(row_out), 32'h0);
    chk("reset_col_out", 32'(col_out), 32'hFF);
    chk("reset_frame_start", 32'(frame_start), 32'h0);
    chk("reset_swap_ack", 32'(swap_ack), 32'h0);

    // Enable with empty buffers.
    enable = 1'b1;
    @(negedge clk);
    chk("first_frame_start", 32'(frame_start), 32'h1);
    chk("first_blank_row", 32'(row_out), 32'h0);
    @(negedge clk);
    chk("blank2_frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    chk("row0_on_row", 32'(row_out), 32'h1);
    chk("row0_on_col_blank_img", 32'(col_out), 32'hFF);

    // Fill back buffer, request swap mid-frame, overwrite row 2 on the swap edge.
    for (int i = 0; i < ROWS; i++) begin
      wr_en   = 1'b1;
      wr_row  = 2'(i);
      wr_data = 8'(1 << i);
      @(negedge clk);
    end
    wr_en    = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_pos(FRAME - 1);
    wr_en   = 1'b1;
    wr_row  = 2'd2;
    wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    chk("swap_ack_at_boundary", 32'(swap_ack), 32'h1);
    chk("swap_frame_start", 32'(frame_start), 32'h1);
    wait_pos(2);
    chk("img_row0_row", 32'(row_out), 32'h1);
    chk("img_row0_col", 32'(col_out), 32'hFE);
    wait_pos(PER + 2);
    chk("img_row1_col", 32'(col_out), 32'hFD);
    wait_pos(2 * PER + 2);
    chk("img_row2_row", 32'(row_out), 32'h4);
    chk("img_row2_col", 32'(col_out), 32'h55);
    wait_pos(3 * PER + 2);
    chk("img_row3_col", 32'(col_out), 32'hF7);

    // Disable during ON of row 2, then re-enable.
    wait_pos(2 * PER + 3);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_row_out", 32'(row_out), 32'h0);
    chk("disable_col_out", 32'(col_out), 32'hFF);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_frame_start", 32'(frame_start), 32'h1);

    // Two requests before one boundary produce one acknowledge.
    wait_pos(3);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (swap_ack) acks++;
    end
    chk("double_req_single_ack", 32'(acks), 32'd1);

    // Put a visible image on the display before the reset test.
    for (int i = 0; i < ROWS; i++) begin
      wr_en   = 1'b1;
      wr_row  = 2'(i);
      wr_data = 8'h0F;
      @(negedge clk);
    end
    wr_en    = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_pos(2);
    wait_pos(PER + 2);
    chk("pre_reset_row1_col", 32'(col_out), 32'hF0);
    // Asynchronous reset during ON of row 1.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_row_out", 32'(row_out), 32'h0);
    chk("async_rst_col_out", 32'(col_out), 32'hFF);
    chk("async_rst_swap_ack", 32'(swap_ack), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_pos(2);
    chk("post_rst_row0_row", 32'(row_out), 32'h1);
    chk("post_rst_image_lost", 32'(col_out), 32'hFF);

    // Randomised soak against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable   = ($urandom_range(0, 99) < 97);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_row   = 2'($urandom);
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
